// File: rtl/edge_event_arbiter_if.sv
// Event bus for edge_event_arbiter. The master side is the arbiter: it takes
// monitored levels and modes in and presents event records out.
interface edge_event_arbiter_if #(
    parameter int NCH = 4
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]   signal_in;
    logic [2*NCH-1:0] mode;
    logic             evt_valid;
    logic             evt_ready;
    logic [CW-1:0]    evt_ch;
    logic             evt_rise;
    logic [NCH-1:0]   overflow;
    logic             ovf_clr;

    modport master (
        input  signal_in, mode, evt_ready, ovf_clr,
        output evt_valid, evt_ch, evt_rise, overflow
    );

    modport slave (
        output signal_in, mode, evt_ready, ovf_clr,
        input  evt_valid, evt_ch, evt_rise, overflow
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detection with a one-deep pending slot
// per channel, round-robin arbitration into a single valid/ready event register,
// and sticky per-channel overflow flags for edges lost to a full slot.
// Optional macro EDGE_SYNC_EN inserts a two-flop synchronizer ahead of detection.
module edge_event_arbiter #(
    parameter int NCH = 4
) (
    input  logic                clk,
    input  logic                rst,
    edge_event_arbiter_if.master evt_bus
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0] w_sig;
    logic [NCH-1:0] w_edge;
    logic [NCH-1:0] w_gnt;
    logic           w_load;
    logic           w_gnt_vld;
    logic [CW-1:0]  w_gnt_idx;
    logic [CW-1:0]  w_ptr_nxt;

    logic [NCH-1:0] r_sig_q;
    logic [NCH-1:0] r_pending;
    logic [NCH-1:0] r_ptype;
    logic [NCH-1:0] r_ovf;
    logic [CW-1:0]  r_rr_ptr;
    logic           r_valid;
    logic [CW-1:0]  r_ch;
    logic           r_rise;

`ifdef EDGE_SYNC_EN
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;

    // Two-flop synchronizer; preloaded with the raw input in reset so release
    // never manufactures an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= evt_bus.signal_in;
            r_sync2 <= evt_bus.signal_in;
        end else begin
            r_sync1 <= evt_bus.signal_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sig = r_sync2;
`else
    assign w_sig = evt_bus.signal_in;
`endif

    // Edge present when the level moved and the mode enables that direction
    // (mode bit 2i = rising, bit 2i+1 = falling).
    always_comb begin
        w_edge = '0;
        for (int i = 0; i < NCH; i++) begin
            w_edge[i] = (w_sig[i] != r_sig_q[i]) &&
                        (w_sig[i] ? evt_bus.mode[2*i] : evt_bus.mode[2*i+1]);
        end
    end

    // Round-robin pick among registered pending bits, starting at r_rr_ptr;
    // only meaningful when the output register can take a new record.
    always_comb begin
        w_load    = !r_valid || evt_bus.evt_ready;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt     = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_gnt_vld && r_pending[(int'(r_rr_ptr) + k) % NCH]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = CW'((int'(r_rr_ptr) + k) % NCH);
            end
        end
        if (!w_load) begin
            w_gnt_vld = 1'b0;
        end
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
        w_ptr_nxt = (w_gnt_idx == CW'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;
    end

    // Output register, pending/direction slots, overflow flags and pointer.
    // A channel granted this cycle frees its slot, so a coincident new edge
    // refills it instead of counting as an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q   <= evt_bus.signal_in;
            r_pending <= '0;
            r_ptype   <= '0;
            r_ovf     <= '0;
            r_rr_ptr  <= '0;
            r_valid   <= 1'b0;
            r_ch      <= '0;
            r_rise    <= 1'b0;
        end else begin
            r_sig_q <= w_sig;
            if (w_load) begin
                r_valid <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_ch     <= w_gnt_idx;
                    r_rise   <= r_ptype[w_gnt_idx];
                    r_rr_ptr <= w_ptr_nxt;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (w_edge[i] && (!r_pending[i] || w_gnt[i])) begin
                    r_pending[i] <= 1'b1;
                    r_ptype[i]   <= w_sig[i];
                end else if (w_gnt[i]) begin
                    r_pending[i] <= 1'b0;
                end
                if (w_edge[i] && r_pending[i] && !w_gnt[i]) begin
                    r_ovf[i] <= 1'b1;
                end else if (evt_bus.ovf_clr) begin
                    r_ovf[i] <= 1'b0;
                end
            end
        end
    end

    assign evt_bus.evt_valid = r_valid;
    assign evt_bus.evt_ch    = r_ch;
    assign evt_bus.evt_rise  = r_rise;
    assign evt_bus.overflow  = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random traffic, all
// checked every cycle against an event-queue style reference model.
module tb_edge_event_arbiter;
    localparam int NCH = 4;
`ifdef EDGE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    edge_event_arbiter_if #(.NCH(NCH)) bus ();
    edge_event_arbiter #(.NCH(NCH)) dut (.clk(clk), .rst(rst), .evt_bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    bit             m_valid;
    int             m_ch;
    bit             m_rise;
    int             m_ptr;
    logic [NCH-1:0] m_pend, m_dir, m_ovf, m_prev, m_s1, m_s2;

    task automatic model_step();
        logic [NCH-1:0] seen;
        int g;
        bit ovf_set;
        if (rst) begin
            m_valid = 0; m_ch = 0; m_rise = 0; m_ptr = 0;
            m_pend = '0; m_dir = '0; m_ovf = '0;
            m_prev = bus.signal_in; m_s1 = bus.signal_in; m_s2 = bus.signal_in;
            return;
        end
        seen = (SYNC != 0) ? m_s2 : bus.signal_in;
        g = -1;
        if (!m_valid || bus.evt_ready) begin
            for (int k = 0; k < NCH; k++)
                if (g < 0 && m_pend[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_ch = g; m_rise = m_dir[g]; m_pend[g] = 1'b0; m_ptr = (g + 1) % NCH;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            ovf_set = 0;
            if (seen[i] != m_prev[i] && bus.mode[2*i + (seen[i] ? 0 : 1)]) begin
                if (m_pend[i]) ovf_set = 1;
                else begin m_pend[i] = 1'b1; m_dir[i] = seen[i]; end
            end
            m_ovf[i] = ovf_set ? 1'b1 : (bus.ovf_clr ? 1'b0 : m_ovf[i]);
        end
        m_prev = seen;
        m_s2 = m_s1;
        m_s1 = bus.signal_in;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("valid", bus.evt_valid, m_valid);
            if (m_valid) begin
                chk("ch", bus.evt_ch, m_ch);
                chk("rise", bus.evt_rise, m_rise);
            end
            chk("ovf", bus.overflow, m_ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_evt(input string tag);
        int lat = 0;
        do begin
            cyc();
            lat++;
        end while (!bus.evt_valid && lat < 20);
        chk(tag, lat, 2 + SYNC);
    endtask

    task automatic quiet(input string tag, input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (bus.evt_valid) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.signal_in = '0;
        bus.mode      = 8'h55;
        bus.evt_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
        do_reset(3);
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_ch", bus.evt_ch, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk_en = 1'b1;

        // Rising-only: ch1 rise reported once, fall ignored
        cyc();
        bus.signal_in[1] = 1'b1;
        wait_evt("lat_rise");
        chk("r30_ch", bus.evt_ch, 1);
        chk("r30_rise", bus.evt_rise, 1);
        cyc();
        chk("r30_single", bus.evt_valid, 0);
        bus.signal_in[1] = 1'b0;
        quiet("r30_nofall", 6);

        // Falling-only on ch2, then both directions
        bus.mode = 8'h65;
        bus.signal_in[2] = 1'b1;
        quiet("r31_norise", 6);
        bus.signal_in[2] = 1'b0;
        wait_evt("lat_fall");
        chk("r31_ch", bus.evt_ch, 2);
        chk("r31_rise", bus.evt_rise, 0);
        quiet("r31_drain", 4);
        bus.mode = 8'h75;
        bus.signal_in[2] = 1'b1;
        wait_evt("lat_both_r");
        chk("r31_b_rise", bus.evt_rise, 1);
        quiet("r31_drain2", 4);
        bus.signal_in[2] = 1'b0;
        wait_evt("lat_both_f");
        chk("r31_b_fall", bus.evt_rise, 0);
        quiet("r31_drain3", 4);

        // Round-robin with wrap
        bus.mode = 8'h55;
        do_reset(2);
        bus.signal_in = 4'b1001;
        wait_evt("lat_rr");
        chk("rr_first", bus.evt_ch, 0);
        cyc();
        chk("rr_second_v", bus.evt_valid, 1);
        chk("rr_second", bus.evt_ch, 3);
        quiet("rr_drain", 4);
        bus.mode = 8'hAA;
        bus.signal_in = 4'b0000;
        wait_evt("lat_rr2");
        chk("rr_wrap_first", bus.evt_ch, 0);
        cyc();
        chk("rr_wrap_second", bus.evt_ch, 3);
        quiet("rr_drain2", 4);

        // Back-pressure and overflow on ch1
        bus.mode = 8'hFF;
        bus.evt_ready = 1'b0;
        bus.signal_in[1] = 1'b1; cyc();
        bus.signal_in[1] = 1'b0; cyc();
        bus.signal_in[1] = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("ovf_set", bus.overflow, 4'b0010);
        chk("ovf_hold_v", bus.evt_valid, 1);
        chk("ovf_hold_ch", bus.evt_ch, 1);
        chk("ovf_hold_rise", bus.evt_rise, 1);
        bus.ovf_clr = 1'b1; cyc();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", bus.overflow, 0);
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        // Reset with inputs high, then reset mid-handshake
        bus.signal_in = 4'hF;
        do_reset(3);
        quiet("rst_no_spur", 6);
        bus.evt_ready = 1'b0;
        bus.signal_in[2] = 1'b0;
        wait_evt("lat_pre_rst");
        bus.signal_in[0] = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("rst_mid_v", bus.evt_valid, 0);
        cyc();
        rst = 1'b0;
        bus.evt_ready = 1'b1;
        quiet("rst_pend_clr", 6);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if (n % 16 == 0) bus.mode = 8'($urandom);
            bus.signal_in = bus.signal_in ^ (4'($urandom) & 4'($urandom));
            bus.evt_ready = ($urandom % 4) != 0;
            bus.ovf_clr   = ($urandom % 16) == 0;
            rst           = ($urandom % 97) == 0;
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: NCH, default 4, number of monitored input channels (2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: signal_in  input  NCH  monitored level signals, bit i = channel i.
REQ-005 Port: mode  input  2*NCH  per-channel detect mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-006 Port: evt_valid  output  1  event record presented.
REQ-007 Port: evt_ready  input  1  consumer accepts record when evt_valid && evt_ready at a clock edge.
REQ-008 Port: evt_ch  output  clog2(NCH)  channel index of presented event.
REQ-009 Port: evt_rise  output  1  1 = rising edge, 0 = falling edge.
REQ-010 Port: overflow  output  NCH  sticky per-channel lost-event flags.
REQ-011 Port: ovf_clr  input  1  clears all overflow bits.

Function
REQ-012 Per channel a registered previous-level sig_q[i] SHALL be kept; edge exists in a cycle when signal_in[i] != sig_q[i] and the mode enables that direction.
REQ-013 A detected edge SHALL set pending[i] and record its direction in ptype[i] at the same clock edge that updates sig_q[i].
REQ-014 Mode changes SHALL take effect on detection in the same cycle; mode 00 SHALL NOT clear an existing pending bit.
REQ-015 Output register SHALL be loadable when evt_valid==0 or (evt_valid && evt_ready).
REQ-016 When loadable and any pending bit set, round-robin selection SHALL start at pointer rr_ptr and pick the first pending channel in ascending index with wrap from NCH-1 to 0.
REQ-017 On load: evt_valid<=1, evt_ch<=granted index, evt_rise<=ptype, pending[granted] cleared, rr_ptr<=(granted+1) mod NCH.
REQ-018 When loadable and no pending bit set, evt_valid SHALL go 0 at the edge (if accepted) or stay 0.
REQ-019 While evt_valid && !evt_ready, evt_valid, evt_ch, evt_rise SHALL hold stable.
REQ-020 Latency: edge first visible on signal_in sampled at edge k -> pending at k -> evt_valid=1 after edge k+1 (if output free and channel wins).
REQ-021 New edge on channel i with pending[i]=1 and channel i not granted that cycle SHALL set overflow[i]; existing ptype[i] retained, new edge dropped.
REQ-022 New edge on channel i in the same cycle channel i is granted SHALL leave pending[i]=1 with the new direction; no overflow.
REQ-023 ovf_clr SHALL clear overflow; if a set condition occurs in the same cycle, set wins.
REQ-024 Throughput: at most one event per cycle; back-to-back accept with continuous evt_ready.

Reset
REQ-025 During rst: evt_valid=0, evt_ch=0, evt_rise=0, pending=0, ptype=0, overflow=0, rr_ptr=0.
REQ-026 During rst, sig_q SHALL load signal_in so no spurious edge is reported on rst release.
REQ-027 rst asserted mid-handshake SHALL discard the presented and all pending events without acceptance.

Configuration
REQ-028 Macro EDGE_SYNC_EN: when defined, each signal_in bit SHALL pass a two-flop synchronizer before sig_q/detection, adding 2 cycles to REQ-020 latency; synchronizer flops load signal_in during rst.
REQ-029 Without EDGE_SYNC_EN, signal_in SHALL feed detection directly with REQ-020 latency.

Verification
REQ-030 NCH=4, mode=all 01, ready=1, ch1 0->1 -> evt_valid for one cycle 2 cycles later, evt_ch=1, evt_rise=1; later 1->0 -> no event.
REQ-031 mode ch2=10, ch2 0->1->0 -> single event evt_ch=2, evt_rise=0; mode 11 -> both edges reported, rise then fall.
REQ-032 rr_ptr=0, ready=1, ch0 and ch3 rise same cycle -> events ch0 then ch3 on consecutive cycles; next simultaneous ch0/ch3 -> ch0 first (ptr=1 wraps).
REQ-033 ready=0, ch1 toggles 3 times -> evt held ch1; second pending edge sets overflow[1]=1; ovf_clr pulse -> overflow=0.
REQ-034 signal_in=4'hF held through rst, rst released -> no event; rst asserted while evt_valid=1, ready=0 -> evt_valid=0 next cycle, pending cleared.
REQ-035 Rerun REQ-030 with EDGE_SYNC_EN defined -> event 4 cycles after edge, same values.
